// File: rtl/iport_fifo_if.sv
// Bus interface for iport_fifo: CPU I/O slave signals plus the producer
// byte stream.
//   master: CPU/decoder side and producer (drives strobes, data, ext_valid)
//   slave : iport_fifo (drives dout, ext_ready, int_n)
interface iport_fifo_if;
  logic       ena;
  logic [1:0] addr;
  logic       iord;
  logic       iowr;
  logic       inta;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;
  logic       int_n;

  modport master (
    output ena, addr, iord, iowr, inta, din, ext_data, ext_valid,
    input  dout, ext_ready, int_n
  );

  modport slave (
    input  ena, addr, iord, iowr, inta, din, ext_data, ext_valid,
    output dout, ext_ready, int_n
  );
endinterface

// File: rtl/iport_fifo.sv
// iport_fifo: Z80 I/O-read slave. A producer pushes bytes over a
// valid/ready handshake into a FIFO; the CPU pops them with IN.
//   masterclk : system clock, all state on rising edge
//   reset_n   : synchronous active-low reset
//   bus       : iport_fifo_if.slave
//               ena/addr/iord/iowr/din/dout : CPU register access
//               inta/int_n                  : interrupt (IM2 vector)
//               ext_data/ext_valid/ext_ready: producer handshake
// Register map: addr 0 = DATA (read pops), addr 1 = STATUS (read) /
// CTRL (write: bit0 ie, bit1 flush, bit2 clear overflow), 2-3 reserved.
// Optional feature: define IPORT_INT_EN to enable the interrupt request
// and the IM2 vector response during INTA.
module iport_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter logic [7:0]  VECTOR = 8'hF0
) (
  input logic        masterclk,
  input logic        reset_n,
  iport_fifo_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 5;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ie;
  logic          iord_q;
  logic          iowr_q;
  logic [7:0]    dout_r;

  logic          empty;
  logic          full;
  logic          rd_acc;
  logic          wr_acc;
  logic          ctrl_wr;
  logic          flush;
  logic          ovf_clr;
  logic          ovf_set;
  logic          pop;
  logic          push;
  logic [7:0]    rd_data;

  // Access decode: strobes act once, on their first cycle high.
  always_comb begin
    empty   = (count == CW'(0));
    full    = (count == CW'(DEPTH));
    rd_acc  = bus.ena & bus.iord & ~iord_q;
    wr_acc  = bus.ena & bus.iowr & ~iowr_q;
    ctrl_wr = wr_acc & (bus.addr == 2'd1);
    flush   = ctrl_wr & bus.din[1];
    ovf_clr = ctrl_wr & bus.din[2];
    ovf_set = bus.ext_valid & full;
    pop     = rd_acc & (bus.addr == 2'd0) & ~empty;
    push    = bus.ext_valid & bus.ext_ready;
  end

  // Read data mux; empty DATA reads and reserved addresses return zero.
  always_comb begin
    rd_data = 8'h00;
    case (bus.addr)
      2'd0:    rd_data = empty ? 8'h00 : mem[rd_ptr];
      2'd1:    rd_data = {overflow, full, empty, count};
      default: rd_data = 8'h00;
    endcase
  end

  assign bus.ext_ready = reset_n & ~full;
  assign bus.dout      = dout_r;

  // Storage array, no reset needed.
  always_ff @(posedge masterclk) begin
    if (push) mem[wr_ptr] <= bus.ext_data;
  end

`ifdef IPORT_INT_EN
  logic inta_q;
  logic int_n_r;
  assign bus.int_n = int_n_r;
`else
  assign bus.int_n = 1'b1;
  logic unused_sig;
  assign unused_sig = ^{bus.inta, VECTOR, ie, bus.din[7:3]};
`endif

  // Pointers, count, flags, read data.
  always_ff @(posedge masterclk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ie       <= 1'b0;
      iord_q   <= 1'b0;
      iowr_q   <= 1'b0;
      dout_r   <= 8'h00;
`ifdef IPORT_INT_EN
      inta_q   <= 1'b0;
      int_n_r  <= 1'b1;
`endif
    end else begin
      iord_q <= bus.iord;
      iowr_q <= bus.iowr;

      // Flush overrides any push/pop on the same edge.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end

      // A new overflow beats a clear on the same edge.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      if (ctrl_wr) ie <= bus.din[0];
      if (rd_acc)  dout_r <= rd_data;

`ifdef IPORT_INT_EN
      inta_q  <= bus.inta;
      if (bus.inta && !inta_q && !int_n_r) dout_r <= VECTOR;
      int_n_r <= ~(ie & ~empty);
`endif
    end
  end

endmodule
